// File: rtl/fsm_pkg.sv
// Shared definitions for the varint encode stage and its downstream merge stage.
package fsm_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} state_t;

  localparam int unsigned VARINT_CONT_BIT = 7;

  function automatic int unsigned MAX_BYTES(input int unsigned data_w);
    return (data_w + VARINT_CONT_BIT - 1) / VARINT_CONT_BIT;
  endfunction

endpackage

// File: rtl/fsm_2.sv
// Varint encode stage: pops one tagged field value, emits its base-128 varint bytes
// into the varint FIFO, then holds varint_data_valid until the merge stage accepts.
module fsm_2
  import fsm_pkg::*;
#(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned INDEX_W = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_fifo_empty,
  output logic               in_fifo_pop,
  input  logic [DATA_W-1:0]  in_fifo_data,
  input  logic [INDEX_W-1:0] in_fifo_index,
  input  logic               varint_fifo_full,
  output logic               varint_fifo_push,
  output logic [7:0]         varint_fifo_data,
  output logic [INDEX_W-1:0] varint_fifo_index,
  output logic               varint_fifo_last,
  output logic               varint_data_valid,
  input  logic               varint_data_accepted
);

  localparam int unsigned NBYTES = MAX_BYTES(DATA_W);
  localparam int unsigned CNT_W  = $clog2(NBYTES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBYTES - 1);

  state_t             state, state_next;
  logic [DATA_W-1:0]  value_r;
  logic [INDEX_W-1:0] index_r;
  logic [CNT_W-1:0]   cnt_r;

  logic       more;
  logic [7:0] fmt_byte;

  // Byte formatter; the saturated byte counter forces the final byte as a guard.
  always_comb begin
    more     = ((value_r >> VARINT_CONT_BIT) != '0) && (cnt_r != CNT_LAST);
    fmt_byte = {more, value_r[VARINT_CONT_BIT-1:0]};
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // LOAD spans two cycles: the registered pop strobe, then the data capture.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!in_fifo_empty) state_next = LOAD;
      LOAD:    if (!in_fifo_pop) state_next = EMIT;
      EMIT:    if (!varint_fifo_full && !more) state_next = DONE;
      DONE:    if (varint_data_accepted) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_r           <= '0;
      index_r           <= '0;
      cnt_r             <= '0;
      in_fifo_pop       <= 1'b0;
      varint_fifo_push  <= 1'b0;
      varint_fifo_data  <= '0;
      varint_fifo_index <= '0;
      varint_fifo_last  <= 1'b0;
      varint_data_valid <= 1'b0;
    end else begin
      in_fifo_pop       <= (state == IDLE) && !in_fifo_empty;
      varint_fifo_push  <= 1'b0;
      varint_fifo_last  <= 1'b0;
      varint_data_valid <= (state_next == DONE);
      if (state == LOAD && !in_fifo_pop) begin
        value_r <= in_fifo_data;
        index_r <= in_fifo_index;
        cnt_r   <= '0;
      end
      if (state == EMIT && !varint_fifo_full) begin
        varint_fifo_push  <= 1'b1;
        varint_fifo_data  <= fmt_byte;
        varint_fifo_index <= index_r;
        varint_fifo_last  <= !more;
        value_r           <= value_r >> VARINT_CONT_BIT;
        if (cnt_r != CNT_LAST) cnt_r <= cnt_r + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fsm_2.sv
// Bench for fsm_2: input FIFO model, byte monitor and an arithmetic varint reference.
module tb_fsm_2;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_fifo_empty;
  logic        in_fifo_pop;
  logic [63:0] in_fifo_data;
  logic [9:0]  in_fifo_index;
  logic        varint_fifo_full;
  logic        varint_fifo_push;
  logic [7:0]  varint_fifo_data;
  logic [9:0]  varint_fifo_index;
  logic        varint_fifo_last;
  logic        varint_data_valid;
  logic        varint_data_accepted;

  fsm_2 #(.DATA_W(64), .INDEX_W(10)) dut (
    .clk                  (clk),
    .reset                (reset),
    .in_fifo_empty        (in_fifo_empty),
    .in_fifo_pop          (in_fifo_pop),
    .in_fifo_data         (in_fifo_data),
    .in_fifo_index        (in_fifo_index),
    .varint_fifo_full     (varint_fifo_full),
    .varint_fifo_push     (varint_fifo_push),
    .varint_fifo_data     (varint_fifo_data),
    .varint_fifo_index    (varint_fifo_index),
    .varint_fifo_last     (varint_fifo_last),
    .varint_data_valid    (varint_data_valid),
    .varint_data_accepted (varint_data_accepted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [9:0] index;
    logic       last;
  } rec_t;
  typedef logic [7:0] bq_t[$];

  rec_t        out_q[$];
  logic [73:0] in_q[$];
  int          pop_count = 0;
  int          pops_exp  = 0;
  int          checks    = 0;
  int          failures  = 0;
  bit          rand_full = 1'b0;

  function automatic bq_t encode(input logic [63:0] v);
    bq_t q;
    logic [63:0] rem = v;
    do begin
      logic [7:0] b = {1'b0, rem[6:0]};
      rem = rem / 128;
      if (rem != 0) b = b + 8'd128;
      q.push_back(b);
    end while (rem != 0);
    return q;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Input field FIFO: data and index present the cycle after a pop.
  initial begin
    bit p;
    forever begin
      @(negedge clk);
      p = in_fifo_pop;
      @(posedge clk);
      #1;
      if (p) begin
        pop_count++;
        if (in_q.size() > 0) {in_fifo_index, in_fifo_data} = in_q.pop_front();
        in_fifo_empty = (in_q.size() == 0);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (varint_fifo_push)
        out_q.push_back('{varint_fifo_data, varint_fifo_index, varint_fifo_last});
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rand_full) varint_fifo_full = ($urandom_range(0, 2) == 0);
    end
  end

  task automatic enqueue(input logic [63:0] v, input logic [9:0] idx);
    in_q.push_back({idx, v});
    in_fifo_empty = 1'b0;
  endtask

  // acc_delay < 0: accept is already held high before the varint completes.
  task automatic finish_field(input logic [63:0] v, input logic [9:0] idx,
                              input int acc_delay, input int stall, input int exp_lat);
    bq_t exp_b = encode(v);
    int  cyc = 0;
    int  stall_left = stall;
    bit  seen = 1'b0;
    pops_exp++;
    if (acc_delay < 0) varint_data_accepted = 1'b1;
    while (!seen && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (varint_data_valid) seen = 1'b1;
      else if (stall_left > 0) begin
        if (!varint_fifo_full && out_q.size() == 1) varint_fifo_full = 1'b1;
        else if (varint_fifo_full) begin
          stall_left--;
          if (stall_left == 0) varint_fifo_full = 1'b0;
        end
      end
    end
    check("valid_seen", 64'(seen), 64'd1);
    if (exp_lat >= 0) check("latency", 64'(cyc), 64'(exp_lat));
    check("pop_count", 64'(pop_count), 64'(pops_exp));
    if (acc_delay > 0) begin
      repeat (acc_delay) @(negedge clk);
      check("valid_held", 64'(varint_data_valid), 64'd1);
      check("no_early_pop", 64'(pop_count), 64'(pops_exp));
    end
    varint_data_accepted = 1'b1;
    @(negedge clk);
    varint_data_accepted = 1'b0;
    check("valid_drop", 64'(varint_data_valid), 64'd0);
    check("byte_count", 64'(out_q.size()), 64'(exp_b.size()));
    for (int i = 0; i < exp_b.size() && i < out_q.size(); i++) begin
      check("byte_data", 64'(out_q[i].data), 64'(exp_b[i]));
      check("byte_index", 64'(out_q[i].index), 64'(idx));
      check("byte_last", 64'(out_q[i].last), 64'(i == exp_b.size() - 1));
    end
    out_q.delete();
  endtask

  task automatic field(input logic [63:0] v, input logic [9:0] idx,
                       input int acc_delay, input int stall, input int exp_lat);
    enqueue(v, idx);
    finish_field(v, idx, acc_delay, stall, exp_lat);
  endtask

  initial begin
    logic [63:0] ones = '1;
    logic [63:0] rv;
    logic [9:0]  ri;
    int          waited;
    reset = 1'b1;
    in_fifo_empty = 1'b1;
    in_fifo_data = '0;
    in_fifo_index = '0;
    varint_fifo_full = 1'b0;
    varint_data_accepted = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pop", 64'(in_fifo_pop), 64'd0);
    check("rst_push", 64'(varint_fifo_push), 64'd0);
    check("rst_valid", 64'(varint_data_valid), 64'd0);
    check("rst_data", 64'(varint_fifo_data), 64'd0);
    check("rst_last", 64'(varint_fifo_last), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_no_pop", 64'(pop_count), 64'd0);

    field(64'd0, 10'd5, 2, 0, 4);
    field(64'd300, 10'd17, 0, 0, 5);
    field(ones, 10'd1023, 1, 0, 13);
    field(64'd300, 10'd17, 0, 3, 8);

    enqueue(64'd129, 10'd3);
    enqueue(64'h0123_4567_89ab_cdef, 10'd4);
    finish_field(64'd129, 10'd3, 4, 0, -1);
    finish_field(64'h0123_4567_89ab_cdef, 10'd4, 0, 0, -1);

    field(64'd127, 10'd8, -1, 0, 4);

    enqueue(ones, 10'd99);
    pops_exp++;
    waited = 0;
    while (out_q.size() < 4 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("four_bytes_before_reset", 64'(out_q.size()), 64'd4);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_push", 64'(varint_fifo_push), 64'd0);
    check("mid_rst_valid", 64'(varint_data_valid), 64'd0);
    out_q.delete();
    @(negedge clk);
    field(64'h1234_5678, 10'd42, 0, 0, 8);

    rand_full = 1'b1;
    for (int n = 0; n < 20; n++) begin
      rv = {$urandom, $urandom};
      rv = rv >> $urandom_range(0, 63);
      ri = 10'($urandom_range(0, 1023));
      field(rv, ri, int'($urandom_range(0, 3)), 0, -1);
    end
    rand_full = 1'b0;
    @(negedge clk);
    varint_fifo_full = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
